axi_write_staging_fifo: RTL and testbench
=========================================

# axi_write_staging_fifo

- Buffers AXI-like write requests (address, data, byte strobe) from an upstream producer and presents them one at a time on the `axi_aw*` / `axi_w*` request bus of the downstream write-protocol stage.
- Decouples producer bursts from downstream back-pressure (`axi_awready`) with a DEPTH-entry first-word-fall-through FIFO.
- Lives entirely in the `clk_domain_a` domain.

## Interface

Parameters:
- `DATA_WIDTH`, default 32 — write data width; multiple of 8.
- `ADDR_WIDTH`, default 16 — write address width.
- `DEPTH`, default 4 — number of FIFO entries; power of 2, ≥ 2.

Ports:
- `clk_domain_a`  in  1  — single clock; all logic on its rising edge.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `flush`  in  1  — synchronous discard of all queued entries.
- `in_valid`  in  1  — producer request valid.
- `in_addr`  in  ADDR_WIDTH  — producer write address.
- `in_data`  in  DATA_WIDTH  — producer write data.
- `in_strb`  in  DATA_WIDTH/8  — producer byte strobes.
- `in_ready`  out  1  — FIFO can accept a request this cycle.
- `axi_awvalid`  out  1  — head entry valid toward downstream.
- `axi_awaddr`  out  ADDR_WIDTH  — head address.
- `axi_wdata`  out  DATA_WIDTH  — head data.
- `axi_wstrb`  out  DATA_WIDTH/8  — head strobes.
- `axi_awready`  in  1  — downstream accepts the head entry.
- `level`  out  $clog2(DEPTH)+1  — current occupancy, 0..DEPTH.
- `overflow`  out  1  — sticky: push attempted while full.
- `drop_count`  out  8  — count of zero-strobe requests discarded (see Configuration).

## Operation

- Storage:
  - DEPTH × (ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH/8) array.
  - Write and read pointers of width $clog2(DEPTH); both wrap modulo DEPTH.
  - Occupancy counter `level`.
- Push: occurs when `in_valid && in_ready` (and the request is not dropped). The entry is written at the write pointer, and the write pointer increments.
- Pop: occurs when `axi_awvalid && axi_awready`. The read pointer increments.
- Push and pop in the same cycle: `level` is unchanged; both pointers advance.
- `in_ready = (level != DEPTH)`. It is combinational from registered state only and never depends on `in_valid` or `axi_awready`.
- `axi_awvalid = (level != 0)`. `axi_awaddr`, `axi_wdata` and `axi_wstrb` show the entry at the read pointer.
- When full, a pop does not free a slot for a push in the same cycle. There is no full-bypass.
- When empty, a push does not appear on the output in the same cycle. There is no empty-bypass.
- Output stability: while `axi_awvalid && !axi_awready`, all `axi_*` outputs hold their values.
- Overflow: `overflow` sets when `in_valid && !in_ready`. It clears only on reset.
- `flush`:
  - Pointers and `level` go to 0 at the next edge.
  - A push or pop in the same cycle is ignored.
  - `overflow` and `drop_count` are not affected.
- Priority, highest first: `rst_n` low > `flush` > push/pop.

## Timing

- Reset values (`rst_n` low at an edge):
  - `level` = 0, `in_ready` = 1, `axi_awvalid` = 0.
  - `axi_awaddr`, `axi_wdata` and `axi_wstrb` are don't-care but must be driven to 0.
  - `overflow` = 0, `drop_count` = 0.
- Reset mid-operation discards all entries with no partial output.
- Latency: a request accepted at edge N into an empty FIFO drives `axi_awvalid` = 1 from edge N to edge N+1, i.e. one-cycle latency.
- Throughput: one push and one pop per cycle sustained.
- `level` updates one cycle after the handshake.

## Configuration

- Macro `ZERO_STRB_DROP_EN`.
- With the macro defined:
  - A request with `in_strb == 0` is handshaken (`in_ready` follows the normal rule) but not enqueued.
  - `drop_count` increments and saturates at 255.
  - `level` is unchanged by that request.
- Without the macro:
  - Zero-strobe requests are enqueued like any other.
  - `drop_count` is tied to 0.

## Test plan

- Reset, then push addr 0x0010, data 0xDEADBEEF, strb 0xF with `axi_awready` = 0 → `axi_awvalid` = 1 one cycle later with those exact values; outputs stable for 5 cycles; `level` = 1.
- Push 5 requests back-to-back with DEPTH = 4 and `axi_awready` = 0 → `in_ready` = 0 after the 4th; the 5th sets `overflow` = 1; `level` = 4; drain yields addresses in order 0, 1, 2, 3.
- Hold `in_valid` = 1 and `axi_awready` = 1 continuously for 20 cycles with incrementing data → 20 pops, zero gaps after the first cycle, order preserved across pointer wrap.
- FIFO at `level` = 3, assert `flush` together with a push and a pop → next cycle `level` = 0, `axi_awvalid` = 0, `overflow` unchanged.
- Mid-stream `rst_n` low for one cycle with `level` = 2 → `level` = 0, `overflow` = 0, `axi_awvalid` = 0 on the following cycle.
- With `ZERO_STRB_DROP_EN` defined, push strb 0x0, then strb 0x3 → `drop_count` = 1, `level` = 1, and the output shows strb 0x3. Without the macro → `level` = 2 and `drop_count` = 0.

Source files
------------

// File: rtl/axi_write_staging_fifo_if.sv
// axi_write_staging_fifo_if: producer request and downstream AXI-like write request bus.
interface axi_write_staging_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ADDR_WIDTH-1:0]     in_addr;
    logic [DATA_WIDTH-1:0]     in_data;
    logic [DATA_WIDTH/8-1:0]   in_strb;
    logic                      axi_awvalid;
    logic                      axi_awready;
    logic [ADDR_WIDTH-1:0]     axi_awaddr;
    logic [DATA_WIDTH-1:0]     axi_wdata;
    logic [DATA_WIDTH/8-1:0]   axi_wstrb;
    modport master (
        output in_valid, in_addr, in_data, in_strb, axi_awready,
        input  in_ready, axi_awvalid, axi_awaddr, axi_wdata, axi_wstrb
    );
    modport slave (
        input  in_valid, in_addr, in_data, in_strb, axi_awready,
        output in_ready, axi_awvalid, axi_awaddr, axi_wdata, axi_wstrb
    );
endinterface

// File: rtl/axi_write_staging_fifo.sv
// axi_write_staging_fifo: FWFT staging FIFO for write requests, no full/empty bypass.
// Define ZERO_STRB_DROP_EN to discard zero-strobe requests and count them in drop_count.
module axi_write_staging_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                     clk_domain_a,
    input  logic                     rst_n,
    input  logic                     flush,
    axi_write_staging_fifo_if.slave  bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [SW-1:0]         strb_q [DEPTH];
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  push, pop, drop;

`ifdef ZERO_STRB_DROP_EN
    logic [7:0] drop_q;
    assign drop = bus.in_strb == '0;
    always_ff @(posedge clk_domain_a) begin
        if (!rst_n)
            drop_q <= '0;
        else if (bus.in_valid && bus.in_ready && drop && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end
    assign drop_count = drop_q;
`else
    assign drop       = 1'b0;
    assign drop_count = '0;
`endif

    assign bus.in_ready    = level_q != LW'(DEPTH);
    assign bus.axi_awvalid = level_q != '0;
    // Head fields are forced to 0 while empty so reset leaves them driven low.
    assign bus.axi_awaddr  = bus.axi_awvalid ? addr_q[rd_q] : '0;
    assign bus.axi_wdata   = bus.axi_awvalid ? data_q[rd_q] : '0;
    assign bus.axi_wstrb   = bus.axi_awvalid ? strb_q[rd_q] : '0;
    assign push            = bus.in_valid && bus.in_ready && !drop;
    assign pop             = bus.axi_awvalid && bus.axi_awready;
    assign level           = level_q;
    assign overflow        = ovf_q;

    always_comb begin
        wr_d    = flush ? '0 : push ? wr_q + PW'(1) : wr_q;
        rd_d    = flush ? '0 : pop ? rd_q + PW'(1) : rd_q;
        level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
        ovf_d   = ovf_q || (bus.in_valid && !bus.in_ready);
    end

    always_ff @(posedge clk_domain_a) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_domain_a) begin
        if (push && !flush) begin
            addr_q[wr_q] <= bus.in_addr;
            data_q[wr_q] <= bus.in_data;
            strb_q[wr_q] <= bus.in_strb;
        end
    end
endmodule

// File: tb/tb_axi_write_staging_fifo.sv
// tb_axi_write_staging_fifo: directed scoreboard bench for axi_write_staging_fifo.
module tb_axi_write_staging_fifo;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int DEPTH = 4;
    localparam int SW = DW / 8;
    localparam int EW = AW + DW + SW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] level;
    logic       overflow;
    logic [7:0] drop_count;

    logic [EW-1:0] sb [$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   p0 = 0;
    logic m_ovf = 1'b0;
    int   m_drop = 0;

    always #5 clk = ~clk;

    axi_write_staging_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi_write_staging_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_domain_a (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .level        (level),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic verify();
        check("level", 64'(level), 64'(sb.size()));
        check("in_ready", 64'(bus.in_ready), 64'(sb.size() != DEPTH));
        check("awvalid", 64'(bus.axi_awvalid), 64'(sb.size() != 0));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_count", 64'(drop_count), 64'(m_drop));
        if (sb.size() != 0)
            check("head", 64'({bus.axi_awaddr, bus.axi_wdata, bus.axi_wstrb}), 64'(sb[0]));
    endtask

    task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic rdy, input logic fl);
        bit full;
        bit dr;
        bus.in_valid = v;
        bus.in_addr = a;
        bus.in_data = d;
        bus.in_strb = s;
        bus.axi_awready = rdy;
        flush = fl;
        full = sb.size() == DEPTH;
        dr = 1'b0;
`ifdef ZERO_STRB_DROP_EN
        dr = s == '0;
`endif
        if (v && full) m_ovf = 1'b1;
        if (v && !full && dr && m_drop < 255) m_drop++;
        if (fl) sb.delete();
        else begin
            if (rdy && sb.size() != 0) begin
                void'(sb.pop_front());
                pops++;
            end
            if (v && !full && !dr) sb.push_back({a, d, s});
        end
        @(posedge clk);
        #1;
        verify();
    endtask

    task automatic do_reset(input logic v);
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = v;
        bus.in_addr = 16'h00AA;
        bus.in_data = 32'h1234_5678;
        bus.in_strb = 4'hF;
        bus.axi_awready = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        m_ovf = 1'b0;
        m_drop = 0;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        verify();
        check("rst_head", 64'({bus.axi_awaddr, bus.axi_wdata, bus.axi_wstrb}), 64'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_addr = '0;
        bus.in_data = '0;
        bus.in_strb = '0;
        bus.axi_awready = 1'b0;
        do_reset(1'b0);

        // single push, held under back-pressure, then drained
        cyc(1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 0);
        check("t1_awvalid", 64'(bus.axi_awvalid), 64'd1);
        check("t1_head", 64'({bus.axi_awaddr, bus.axi_wdata, bus.axi_wstrb}), {12'd0, 16'h0010, 32'hDEADBEEF, 4'hF});
        repeat (5) cyc(0, '0, '0, '0, 0, 0);
        check("t1_level", 64'(level), 64'd1);
        cyc(0, '0, '0, '0, 1, 0);

        // fill past full, then drain in order
        for (int i = 0; i < 5; i++) cyc(1, 16'(i), 32'hA000_0000 + 32'(i), 4'hF, 0, 0);
        check("t2_overflow", 64'(overflow), 64'd1);
        check("t2_level", 64'(level), 64'd4);
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            check("t2_order", 64'(bus.axi_awaddr), 64'(i));
            cyc(0, '0, '0, '0, 1, 0);
        end
        check("t2_pops", 64'(pops - p0), 64'd4);

        // sustained streaming across pointer wrap
        p0 = pops;
        for (int i = 0; i < 20; i++) cyc(1, 16'(100 + i), 32'(1000 + i), 4'hF, 1, 0);
        cyc(0, '0, '0, '0, 1, 0);
        check("t3_pops", 64'(pops - p0), 64'd20);

        // flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) cyc(1, 16'(16'h40 + i), 32'(i), 4'h1, 0, 0);
        check("t4_level_pre", 64'(level), 64'd3);
        cyc(1, 16'h0050, 32'h5, 4'hF, 1, 1);
        check("t4_awvalid", 64'(bus.axi_awvalid), 64'd0);
        check("t4_overflow", 64'(overflow), 64'd1);

        // mid-stream reset
        for (int i = 0; i < 2; i++) cyc(1, 16'(16'h60 + i), 32'(i), 4'hF, 0, 0);
        check("t5_level_pre", 64'(level), 64'd2);
        do_reset(1'b1);
        check("t5_overflow", 64'(overflow), 64'd0);

        // zero-strobe handling
        cyc(1, 16'h0020, 32'h1111_1111, 4'h0, 0, 0);
        cyc(1, 16'h0021, 32'h2222_2222, 4'h3, 0, 0);
`ifdef ZERO_STRB_DROP_EN
        check("t6_level", 64'(level), 64'd1);
        check("t6_drop", 64'(drop_count), 64'd1);
        check("t6_strb", 64'(bus.axi_wstrb), 64'h3);
`else
        check("t6_level", 64'(level), 64'd2);
        check("t6_drop", 64'(drop_count), 64'd0);
        check("t6_strb", 64'(bus.axi_wstrb), 64'h0);
`endif
        repeat (3) cyc(0, '0, '0, '0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
